iob_fifo_rd_stream: RTL and testbench

Read-side drain engine for the synchronous FIFOs. It pops a programmed number of words from a FIFO read port that has one cycle of read latency and re-times them onto a valid/ready stream with a last-word marker. It sits directly downstream of the asymmetric FIFO: `fifo_data` connects to the FIFO's wide `data_out`, `fifo_empty` to `empty`, and `fifo_read_en` to `read_en`.

---
 rtl/iob_fifo_rd_stream.sv | 127 ++++++++++++
 tb/tb_iob_fifo_rd_stream.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo_rd_stream.sv
// Read-side drain engine: pops a programmed number of words from a 1-cycle-latency
// FIFO read port and re-times them onto a valid/ready stream with a last marker.
module iob_fifo_rd_stream #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  word_cnt,
  input  logic              fifo_empty,
  output logic              fifo_read_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int unsigned DEPTH  = 3;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CRED_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued;
  logic               inflight;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   occ;
  logic [DATA_W-1:0]  buf_q [DEPTH];
  logic               credit_ok;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A read is only issued when the buffer has room for it plus any word still in flight.
  assign credit_ok    = (CRED_W'(occ) + CRED_W'(inflight)) < CRED_W'(DEPTH);
  assign fifo_read_en = (state == RUN) & ~fifo_empty & credit_ok & (issued < len_q);

  assign push    = inflight;
  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;
  assign m_data  = buf_q[rd_ptr];
  assign m_last  = m_valid & (word_cnt == len_q - LEN_W'(1));

  // Output buffer storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr] <= fifo_data;
    end
  end

  // Control FSM, buffer pointers and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      word_cnt <= '0;
      len_q    <= '0;
      issued   <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= fifo_read_en;

      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        word_cnt <= word_cnt + LEN_W'(1);
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + PTR_W'(1);
        2'b01:   occ <= occ - PTR_W'(1);
        default: occ <= occ;
      endcase

      if (fifo_read_en) begin
        issued <= issued + LEN_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            word_cnt <= '0;
            if (len != '0) begin
              len_q  <= len;
              issued <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fifo_read_en && (issued + LEN_W'(1) == len_q)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_fifo_rd_stream.sv
// Scoreboard bench for iob_fifo_rd_stream: FIFO model with 1-cycle read latency,
// expected stream words queued at stimulus time and compared on each accept.
module tb_iob_fifo_rd_stream;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 16;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              l;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  word_cnt;
  logic              fifo_empty;
  logic              fifo_read_en;
  logic [DATA_W-1:0] fifo_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [$];
  exp_t              exp_q [$];
  int                fcnt = 0;
  int                rd_cnt = 0;
  int                acc_cnt = 0;
  int                done_cnt = 0;
  int                cyc = 0;
  int                done_cyc = -1;
  int                first_acc = -1;
  int                last_acc = -1;

  logic              prev_valid = 1'b0;
  logic              prev_ready = 1'b0;
  logic              prev_last = 1'b0;
  logic              prev_rst = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  iob_fifo_rd_stream #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .word_cnt     (word_cnt),
    .fifo_empty   (fifo_empty),
    .fifo_read_en (fifo_read_en),
    .fifo_data    (fifo_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (fcnt == 0);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic fpush(input logic [DATA_W-1:0] d);
    mem.push_back(d);
    fcnt++;
  endtask

  task automatic epush(input logic [DATA_W-1:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic fifo_clear();
    mem.delete();
    fcnt = 0;
  endtask

  task automatic go(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      if (toggle) m_ready = ~m_ready;
      n++;
    end
    chk("done_timeout", 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"},  64'(busy),         64'd0);
    chk({tag, "_done"},  64'(done),         64'd0);
    chk({tag, "_valid"}, 64'(m_valid),      64'd0);
    chk({tag, "_last"},  64'(m_last),       64'd0);
    chk({tag, "_rden"},  64'(fifo_read_en), 64'd0);
    chk({tag, "_wcnt"},  64'(word_cnt),     64'd0);
  endtask

  // FIFO model: registered read data, garbage when not read.
  always @(posedge clk) begin
    cyc++;
    if (m_valid === 1'b1 && m_ready === 1'b1) acc_cnt++;
    if (fifo_read_en === 1'b1) begin
      chk("rd_while_empty", 64'(fcnt == 0), 64'd0);
      rd_cnt++;
      if (mem.size() > 0) begin
        fifo_data <= mem.pop_front();
        fcnt--;
      end else begin
        fifo_data <= $urandom();
      end
    end else begin
      fifo_data <= $urandom();
    end
  end

  // Stream monitor and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (fifo_read_en === 1'b1) begin
      chk("credit", 64'((rd_cnt - acc_cnt) < 3), 64'd1);
    end
    if (prev_rst && prev_valid === 1'b1 && prev_ready === 1'b0) begin
      chk("stall_valid", 64'(m_valid), 64'd1);
      chk("stall_data",  64'(m_data),  64'(prev_data));
      chk("stall_last",  64'(m_last),  64'(prev_last));
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 64'(m_data), 64'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        chk("data", 64'(m_data), 64'(e.d));
        chk("last", 64'(m_last), 64'(e.l));
      end
    end
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    prev_rst   = rst;
  end

  initial begin
    int t0;
    int d0;
    int n;
    int bz;
    int re;

    rst     = 1'b0;
    start   = 1'b0;
    len     = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic transfer with latency and throughput checks.
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      fpush(DATA_W'(i * 'h11));
      epush(DATA_W'(i * 'h11), i == 4);
    end
    first_acc = -1;
    t0 = cyc;
    go(16'd4);
    wait_done(40, 1'b0);
    chk("basic_first_lat", 64'(first_acc), 64'(t0 + 3));
    chk("basic_last_cyc",  64'(last_acc),  64'(t0 + 6));
    chk("basic_done_cyc",  64'(done_cyc),  64'(t0 + 7));
    chk("basic_wcnt",      64'(word_cnt),  64'd4);
    chk("basic_busy",      64'(busy),      64'd0);
    chk("basic_drained",   64'(exp_q.size()), 64'd0);

    // Zero length: single done pulse, no reads, no busy.
    fpush(32'h5555_0001);
    fpush(32'h5555_0002);
    d0 = done_cnt;
    t0 = cyc;
    bz = 0;
    re = 0;
    go(16'd0);
    repeat (5) begin
      @(negedge clk);
      if (busy) bz++;
      if (fifo_read_en) re++;
    end
    @(posedge clk); #1;
    chk("zero_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("zero_done_cyc", 64'(done_cyc),      64'(t0 + 1));
    chk("zero_busy",     64'(bz),            64'd0);
    chk("zero_rden",     64'(re),            64'd0);
    chk("zero_wcnt",     64'(word_cnt),      64'd0);
    fifo_clear();

    // Downstream backpressure with a full FIFO.
    for (int i = 0; i < 8; i++) begin
      fpush(32'hB000_0000 + DATA_W'(i));
      epush(32'hB000_0000 + DATA_W'(i), i == 7);
    end
    m_ready = 1'b1;
    go(16'd8);
    wait_done(100, 1'b1);
    m_ready = 1'b1;
    chk("bp_wcnt",    64'(word_cnt),     64'd8);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Starved FIFO: two words now, three more ten cycles later.
    fpush(32'hC000_0001);
    fpush(32'hC000_0002);
    for (int i = 1; i <= 5; i++) epush(32'hC000_0000 + DATA_W'(i), i == 5);
    d0 = done_cnt;
    go(16'd5);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("starve_busy", 64'(busy), 64'd1);
    chk("starve_done_early", 64'(done_cnt - d0), 64'd0);
    for (int i = 3; i <= 5; i++) fpush(32'hC000_0000 + DATA_W'(i));
    wait_done(60, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("starve_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("starve_wcnt",     64'(word_cnt),      64'd5);
    chk("starve_drained",  64'(exp_q.size()),  64'd0);

    // Reset after the third of six words is accepted.
    rd_cnt  = 0;
    acc_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      fpush(32'hD000_0000 + DATA_W'(i));
      epush(32'hD000_0000 + DATA_W'(i), i == 6);
    end
    go(16'd6);
    n = 0;
    while (acc_cnt < 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_third_seen", 64'(acc_cnt), 64'd3);
    m_ready = 1'b0;
    rst     = 1'b0;
    d0      = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    chk_reset_outs("abort");
    exp_q.delete();
    fifo_clear();
    rd_cnt  = 0;
    acc_cnt = 0;
    m_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_busy",    64'(busy),          64'd0);
    fpush(32'hE000_0001);
    fpush(32'hE000_0002);
    epush(32'hE000_0001, 1'b0);
    epush(32'hE000_0002, 1'b1);
    go(16'd2);
    wait_done(40, 1'b0);
    chk("post_rst_wcnt",    64'(word_cnt),     64'd2);
    chk("post_rst_drained", 64'(exp_q.size()), 64'd0);

    // Start pulse while busy must be ignored.
    rd_cnt = 0;
    for (int i = 1; i <= 5; i++) fpush(32'hF000_0000 + DATA_W'(i));
    for (int i = 1; i <= 3; i++) epush(32'hF000_0000 + DATA_W'(i), i == 3);
    d0 = done_cnt;
    go(16'd3);
    go(16'd9);
    wait_done(40, 1'b0);
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("busy_start_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("busy_start_reads",    64'(rd_cnt),        64'd3);
    chk("busy_start_wcnt",     64'(word_cnt),      64'd3);
    chk("busy_start_idle",     64'(busy),          64'd0);
    chk("busy_start_drained",  64'(exp_q.size()),  64'd0);
    fifo_clear();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
